// File: rtl/fifo_tree_merge_arbiter.sv
// Merge node of the clause/literal FIFO tree: round-robin pops from child FIFOs,
// absorbs their one-cycle read latency in a 3-entry queue and feeds one parent FIFO.
module fifo_tree_merge_arbiter #(
   parameter int DATA_WIDTH = 36,
   parameter int NUM_PORTS  = 4,
   parameter int PORT_BITS  = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            en_i,
   input  logic [NUM_PORTS-1:0]            src_empty_i,
   input  logic [NUM_PORTS-1:0]            src_valid_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] src_data_i,
   output logic [NUM_PORTS-1:0]            src_read_en_o,
   input  logic                            dst_full_i,
   output logic                            dst_write_en_o,
   output logic [DATA_WIDTH-1:0]           dst_data_o,
   output logic [PORT_BITS-1:0]            grant_id_o,
   output logic                            busy_o
);

   localparam int                   PB1        = PORT_BITS + 1;
   localparam logic [PORT_BITS-1:0] LAST_PORT  = PORT_BITS'(NUM_PORTS - 1);
   localparam logic [PORT_BITS:0]   PORT_COUNT = PB1'(NUM_PORTS);

   logic [PORT_BITS-1:0]  rr_q, rr_d;
   logic                  inflight_q, inflight_d;
   logic [PORT_BITS-1:0]  inflight_id_q, inflight_id_d;
   logic [1:0]            count_q, count_d;
   logic [1:0]            head_q, head_d;
   logic [1:0]            tail_q, tail_d;
   logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
   logic [DATA_WIDTH-1:0] mem_q [3];
   logic [DATA_WIDTH-1:0] mem_d [3];

   logic [DATA_WIDTH-1:0] src_words [NUM_PORTS];
   logic                  credit;
   logic                  grant_valid;
   logic [PORT_BITS-1:0]  grant_id;
   logic [PORT_BITS:0]    search_sum;
   logic [PORT_BITS-1:0]  search_idx;
   logic                  capture;
   logic                  drain;

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
      assign src_words[k] = src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // A pop is only issued when the queue is guaranteed room for it, counting the word still in flight.
   always_comb begin
      credit      = en_i && !reset && (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
      grant_valid = 1'b0;
      grant_id    = '0;
      search_sum  = '0;
      search_idx  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         search_sum = {1'b0, rr_q} + PB1'(i);
         if (search_sum >= PORT_COUNT) begin
            search_sum = search_sum - PORT_COUNT;
         end
         search_idx = search_sum[PORT_BITS-1:0];
         if (credit && !grant_valid && !src_empty_i[search_idx]) begin
            grant_valid = 1'b1;
            grant_id    = search_idx;
         end
      end
   end

   always_comb begin
      src_read_en_o = '0;
      if (grant_valid) begin
         src_read_en_o[grant_id] = 1'b1;
      end
   end

   assign grant_id_o     = grant_id;
   assign capture        = inflight_q && src_valid_i[inflight_id_q];
   assign drain          = !reset && (count_q != 2'd0) && !dst_full_i;
   assign dst_write_en_o = drain;
   assign dst_data_o     = reset ? '0 : ((count_q != 2'd0) ? mem_q[head_q] : last_data_q);
   assign busy_o         = !reset && ((count_q != 2'd0) || inflight_q);

   // A child that flagged non-empty but returns no valid simply releases its credit.
   always_comb begin
      rr_d          = rr_q;
      inflight_d    = grant_valid;
      inflight_id_d = grant_id;
      count_d       = count_q;
      head_d        = head_q;
      tail_d        = tail_q;
      last_data_d   = dst_data_o;
      mem_d         = mem_q;
      if (grant_valid) begin
         rr_d = (grant_id == LAST_PORT) ? '0 : grant_id + PORT_BITS'(1);
      end
      if (capture) begin
         mem_d[tail_q] = src_words[inflight_id_q];
         tail_d        = (tail_q == 2'd2) ? 2'd0 : tail_q + 2'd1;
      end
      if (drain) begin
         head_d = (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
      end
      case ({capture, drain})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q          <= '0;
         inflight_q    <= 1'b0;
         inflight_id_q <= '0;
         count_q       <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         last_data_q   <= '0;
      end else begin
         rr_q          <= rr_d;
         inflight_q    <= inflight_d;
         inflight_id_q <= inflight_id_d;
         count_q       <= count_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         last_data_q   <= last_data_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Credit accounting makes a capture into a full queue impossible.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(capture && count_q == 2'd3));
      end
   end

endmodule

// File: tb/tb_fifo_tree_merge_arbiter.sv
// Self-checking bench: emulated child FIFOs plus a word-level scoreboard model
// of the merge node, checked every cycle, with directed scenarios and a random phase.
module tb_fifo_tree_merge_arbiter;

   localparam int DW = 36;
   localparam int NP = 4;
   localparam int PB = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             en_i;
   logic [NP-1:0]    src_empty_i;
   logic [NP-1:0]    src_valid_i;
   logic [NP*DW-1:0] src_data_i;
   logic [NP-1:0]    src_read_en_o;
   logic             dst_full_i;
   logic             dst_write_en_o;
   logic [DW-1:0]    dst_data_o;
   logic [PB-1:0]    grant_id_o;
   logic             busy_o;

   always #5 clk = ~clk;

   fifo_tree_merge_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_PORTS  (NP),
      .PORT_BITS  (PB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .en_i           (en_i),
      .src_empty_i    (src_empty_i),
      .src_valid_i    (src_valid_i),
      .src_data_i     (src_data_i),
      .src_read_en_o  (src_read_en_o),
      .dst_full_i     (dst_full_i),
      .dst_write_en_o (dst_write_en_o),
      .dst_data_o     (dst_data_o),
      .grant_id_o     (grant_id_o),
      .busy_o         (busy_o)
   );

   // Child FIFO contents; a phantom port claims non-empty but answers a read with no valid.
   logic [DW-1:0] child_q [NP][$];
   bit            phantom [NP];
   logic [NP-1:0] rd_seen;

   // Reference model: words captured but not yet written, plus the one word in flight.
   logic [DW-1:0] sb_q [$];
   bit            inflight_m;
   bit            inflight_lost;
   logic [DW-1:0] inflight_word;
   logic [DW-1:0] last_shown;
   int            rr_m;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int grant_log [$];
   int write_cycles [$];
   int write_cnt = 0;

   function automatic logic [DW-1:0] randWord();
      return {4'($urandom), 32'($urandom)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic refreshEmpty();
      for (int k = 0; k < NP; k++) begin
         src_empty_i[k] = !(child_q[k].size() > 0 || phantom[k]);
      end
   endtask

   task automatic checkOutput();
      bit            gv;
      int            g;
      int            p;
      bit            exp_wr;
      bit            exp_busy;
      logic [NP-1:0] exp_rd;
      logic [DW-1:0] exp_data;
      gv = 1'b0;
      g  = 0;
      if (!reset && en_i && (sb_q.size() + int'(inflight_m)) < 3) begin
         for (int i = 0; i < NP; i++) begin
            p = (rr_m + i) % NP;
            if (!gv && !src_empty_i[p]) begin
               gv = 1'b1;
               g  = p;
            end
         end
      end
      exp_rd   = gv ? (4'b0001 << g) : 4'b0000;
      exp_wr   = !reset && sb_q.size() != 0 && !dst_full_i;
      exp_data = reset ? '0 : ((sb_q.size() != 0) ? sb_q[0] : last_shown);
      exp_busy = !reset && (sb_q.size() != 0 || inflight_m);
      chk("read_en", 64'(src_read_en_o), 64'(exp_rd));
      chk("grant_id", 64'(grant_id_o), gv ? 64'(g) : 64'd0);
      chk("write_en", 64'(dst_write_en_o), 64'(exp_wr));
      chk("dst_data", 64'(dst_data_o), 64'(exp_data));
      chk("busy", 64'(busy_o), 64'(exp_busy));

      rd_seen = src_read_en_o;
      if (|src_read_en_o) grant_log.push_back(int'(grant_id_o));
      if (dst_write_en_o) begin
         write_cycles.push_back(cyc);
         write_cnt++;
      end

      if (reset) begin
         sb_q.delete();
         inflight_m    = 1'b0;
         inflight_lost = 1'b0;
         rr_m          = 0;
         last_shown    = '0;
      end else begin
         last_shown = exp_data;
         if (exp_wr) void'(sb_q.pop_front());
         if (inflight_m && !inflight_lost) sb_q.push_back(inflight_word);
         inflight_m = gv;
         if (gv) begin
            inflight_lost = (child_q[g].size() == 0);
            inflight_word = inflight_lost ? '0 : child_q[g][0];
            rr_m          = (g + 1) % NP;
         end
      end
   endtask

   // Child FIFOs answer last cycle's read enables; unread ports get junk data and stray valids.
   task automatic applyStimulus();
      for (int k = 0; k < NP; k++) begin
         src_valid_i[k]         = 1'b0;
         src_data_i[k*DW +: DW] = randWord();
         if (rd_seen[k]) begin
            if (child_q[k].size() > 0) begin
               src_valid_i[k]         = 1'b1;
               src_data_i[k*DW +: DW] = child_q[k].pop_front();
            end else begin
               phantom[k] = 1'b0;
            end
         end else if ($urandom_range(3) == 0) begin
            src_valid_i[k] = 1'b1;
         end
      end
      refreshEmpty();
   endtask

   task automatic step();
      refreshEmpty();
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
      cyc++;
      applyStimulus();
   endtask

   task automatic stepN(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int n0, n1, w0, w1;

   initial begin
      reset       = 1'b1;
      en_i        = 1'b1;
      dst_full_i  = 1'b0;
      src_valid_i = '0;
      src_data_i  = '0;
      rd_seen     = '0;
      for (int k = 0; k < NP; k++) phantom[k] = 1'b0;
      sb_q.delete();
      inflight_m    = 1'b0;
      inflight_lost = 1'b0;
      inflight_word = '0;
      last_shown    = '0;
      rr_m          = 0;
      stepN(2);
      reset = 1'b0;

      $display("[TB] single word from port 2");
      child_q[2].push_back(36'h0_0000_00AB);
      w0 = write_cnt;
      stepN(5);
      chk("single_write_count", 64'(write_cnt - w0), 64'd1);
      chk("single_busy_end", 64'(busy_o), 64'd0);

      $display("[TB] round-robin fairness");
      reset = 1'b1;
      step();
      reset = 1'b0;
      grant_log.delete();
      write_cycles.delete();
      for (int k = 0; k < NP; k++)
         for (int j = 0; j < 3; j++) child_q[k].push_back(randWord());
      stepN(16);
      chk("rr_grant_count", 64'(grant_log.size()), 64'd12);
      for (int i = 0; i < 12 && i < grant_log.size(); i++)
         chk($sformatf("rr_grant_%0d", i), 64'(grant_log[i]), 64'(i % NP));
      chk("rr_write_count", 64'(write_cycles.size()), 64'd12);
      if (write_cycles.size() == 12)
         chk("rr_no_bubbles", 64'(write_cycles[11] - write_cycles[0]), 64'd11);

      $display("[TB] parent backpressure");
      for (int j = 0; j < 10; j++) child_q[0].push_back(randWord());
      w0 = write_cnt;
      stepN(2);
      dst_full_i = 1'b1;
      n0 = grant_log.size();
      w1 = write_cnt;
      stepN(10);
      n1 = grant_log.size();
      chk("bp_extra_pops_le3", 64'((n1 - n0) <= 3), 64'd1);
      chk("bp_no_write_while_full", 64'(write_cnt - w1), 64'd0);
      chk("bp_busy_while_full", 64'(busy_o), 64'd1);
      dst_full_i = 1'b0;
      stepN(15);
      chk("bp_all_delivered", 64'(write_cnt - w0), 64'd10);

      $display("[TB] empty race on port 1");
      phantom[1] = 1'b1;
      child_q[3].push_back(randWord());
      n0 = grant_log.size();
      w0 = write_cnt;
      stepN(6);
      chk("race_grants", 64'(grant_log.size() - n0), 64'd2);
      if (grant_log.size() >= n0 + 2) begin
         chk("race_first_grant", 64'(grant_log[n0]), 64'd1);
         chk("race_second_grant", 64'(grant_log[n0+1]), 64'd3);
      end
      chk("race_writes", 64'(write_cnt - w0), 64'd1);

      $display("[TB] en_i low mid-stream");
      for (int j = 0; j < 6; j++) child_q[0].push_back(randWord());
      dst_full_i = 1'b1;
      n0 = grant_log.size();
      w0 = write_cnt;
      stepN(3);
      en_i       = 1'b0;
      dst_full_i = 1'b0;
      stepN(8);
      chk("en_pops", 64'(grant_log.size() - n0), 64'd3);
      chk("en_writes", 64'(write_cnt - w0), 64'd3);
      chk("en_busy_low", 64'(busy_o), 64'd0);
      child_q[0].delete();
      en_i = 1'b1;

      $display("[TB] reset mid-stream");
      for (int j = 0; j < 4; j++) begin
         child_q[2].push_back(randWord());
         child_q[3].push_back(randWord());
      end
      dst_full_i = 1'b1;
      stepN(3);
      reset      = 1'b1;
      dst_full_i = 1'b0;
      step();
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_dst_data", 64'(dst_data_o), 64'd0);
      chk("rst_read_en", 64'(src_read_en_o), 64'd0);
      reset = 1'b0;
      n0 = grant_log.size();
      step();
      chk("rst_first_grant", (grant_log.size() > n0) ? 64'(grant_log[n0]) : 64'hFFFF, 64'd2);
      stepN(12);

      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         int k;
         en_i       = ($urandom_range(9) != 0);
         dst_full_i = ($urandom_range(9) < 3);
         reset      = ($urandom_range(99) == 0);
         k          = $urandom_range(NP - 1);
         if ($urandom_range(1) == 0 && child_q[k].size() < 6) child_q[k].push_back(randWord());
         k = $urandom_range(NP - 1);
         if ($urandom_range(31) == 0 && child_q[k].size() == 0) phantom[k] = 1'b1;
         step();
      end

      en_i       = 1'b1;
      dst_full_i = 1'b0;
      reset      = 1'b0;
      stepN(60);
      chk("final_idle", 64'(busy_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_tree_merge_arbiter.md
Name: fifo_tree_merge_arbiter

Overview:
- Merge node of the clause/literal FIFO tree.
- Round-robin arbitrates NUM_PORTS child FIFO buffers and pops one word per cycle from a non-empty child.
- Absorbs the children's 1-cycle read latency in a 3-entry internal queue and pushes words into a single parent FIFO buffer, with backpressure from the parent's full flag.
- Guarantees no word is dropped on either side: it never pops more than the queue can hold, and never writes while the parent is full.

Parameters:
- DATA_WIDTH, 36: word width, matching the FIFO buffers.
- NUM_PORTS, 4: number of child FIFOs, 2..16.
- PORT_BITS, $clog2(NUM_PORTS): width of the port index.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- en_i  in  1  allows new pops when high; in-flight words and the queue still complete and drain when low.
- src_empty_i  in  NUM_PORTS  empty flag per child FIFO.
- src_valid_i  in  NUM_PORTS  data-valid flag per child FIFO, 1 cycle after its read enable.
- src_data_i  in  NUM_PORTS*DATA_WIDTH  child data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- src_read_en_o  out  NUM_PORTS  one-hot-or-zero read enable to the children.
- dst_full_i  in  1  parent FIFO full flag.
- dst_write_en_o  out  1  write enable to the parent FIFO.
- dst_data_o  out  DATA_WIDTH  write data to the parent FIFO.
- grant_id_o  out  PORT_BITS  index of the port popped this cycle; valid when |src_read_en_o.
- busy_o  out  1  high when the queue is non-empty or a pop is in flight.

Behaviour:
Reset (synchronous):
- Outputs: src_read_en_o=0, dst_write_en_o=0, dst_data_o=0, grant_id_o=0, busy_o=0.
- Internal state: rr_ptr=0, queue count=0, queue pointers=0, inflight=0, inflight_id=0.
- Reset mid-operation discards queued and in-flight words; a child word popped in the reset cycle is lost. This is accepted; the tree is reset as a whole.

Grant (combinational, cycle t):
- Eligible ports: port k with src_empty_i[k]=0.
- Credit condition: en_i && (count + inflight) < 3.
- If the credit condition holds and any port is eligible, grant the first eligible port searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_PORTS.
- On a grant: src_read_en_o[g]=1, grant_id_o=g. Otherwise src_read_en_o=0.
- Registered at the edge: inflight<=grant_valid, inflight_id<=g. If granted, rr_ptr<=(g+1) mod NUM_PORTS; otherwise rr_ptr holds.
- At most one read enable is asserted per cycle.

Capture (cycle t+1):
- If inflight && src_valid_i[inflight_id], write that port's slice of src_data_i into the queue tail at the edge.
- src_valid_i on any other port is ignored.
- If inflight && !src_valid_i[inflight_id] (child was empty despite the flag), nothing is captured and the credit is released.

Drain:
- dst_write_en_o = (count != 0) && !dst_full_i.
- dst_data_o = queue head. When count == 0, dst_data_o holds its last value, or 0 after reset.
- On a write, head advances at the edge.

Queue arithmetic:
- 3 entries; 2-bit head/tail pointers wrap 2->0.
- count 0..3: capture+drain in the same cycle leaves count unchanged; capture alone adds 1; drain alone subtracts 1.
- count+inflight never exceeds 3 by construction; overflow is unreachable. An assertion flags capture while count==3.

Latency and throughput:
- Pop at t, dst_write_en_o at t+2 at the earliest. There is no bypass from src to dst.
- Sustained 1 word/cycle when children are non-empty and the parent is not full.

Parent full:
- No write while dst_full_i is high.
- Pops continue until count+inflight reaches 3, then stall.
- The queue resumes draining the cycle dst_full_i falls.

Other:
- en_i falling mid-stream: no new pops; in-flight captures complete and the queue drains.
- busy_o = (count != 0) || inflight.

Test Plan:
- Single word: reset, port 2 holds 0x0_0000_00AB, others empty -> src_read_en_o=4'b0100 at t, dst_write_en_o=1 with dst_data_o=0xAB at t+2, busy_o low at t+3.
- Round-robin fairness: all 4 ports hold 3 words each, dst never full -> grant order 0,1,2,3,0,1,2,3,0,1,2,3; 12 consecutive writes, no bubbles after the first 2 cycles.
- Backpressure: stream from port 0; hold dst_full_i=1 for 10 cycles -> at most 3 extra pops after assertion, count reaches 3, no write while full, all words delivered in order after release with none lost or duplicated.
- Empty race: port 1 empty_i=0 but its FIFO returns src_valid_i=0 -> no capture, count unchanged, next grant issued the following cycle.
- en_i low: en_i drops with count=2, inflight=1 -> no new read enables, 3 words written, busy_o falls.
- Reset mid-stream: assert reset with count=2 -> next cycle all outputs 0, count 0, rr_ptr 0; first grant after release goes to the lowest non-empty port.
